// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - ALU with iterative multiply and optional divide (ALU_MULDIV_DIV_EN)
module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             dz
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, x, y, res_q, alu_res, mul_sum;
    logic             dz_q, is_mul_q, multi, last;
    logic [SW-1:0]    amt;
`ifdef ALU_MULDIV_DIV_EN
    logic             is_rem_q, ge;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff, rem_nx, quo_nx;
`endif

    assign amt  = b[SW-1:0];
    assign last = (cnt == CW'(WIDTH - 1));
`ifdef ALU_MULDIV_DIV_EN
    assign multi = (op == 4'hA) || (op == 4'hB) || (op == 4'hC);
`else
    assign multi = (op == 4'hA);
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            4'h0: alu_res = a + b;
            4'h1: alu_res = a - b;
            4'h2: alu_res = a & b;
            4'h3: alu_res = a | b;
            4'h4: alu_res = a ^ b;
            4'h5: alu_res = a >> amt;
            4'h6: alu_res = $signed(a) >>> amt;
            4'h7: alu_res = a << amt;
            4'h8: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'h9: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            4'hD, 4'hE, 4'hF: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // One iteration step: shift-add multiply, restoring divide
    always_comb begin
        mul_sum = acc + (y[0] ? x : '0);
`ifdef ALU_MULDIV_DIV_EN
        rem_sh   = {acc, x[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, y});
        rem_diff = rem_sh[WIDTH-1:0] - y;
        rem_nx   = ge ? rem_diff : rem_sh[WIDTH-1:0];
        quo_nx   = {x[WIDTH-2:0], ge};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = multi ? BUSY : DONE;
            end
            BUSY: if (last) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            x        <= '0;
            y        <= '0;
            res_q    <= '0;
            dz_q     <= 1'b0;
            is_mul_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            is_rem_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cnt  <= '0;
                    dz_q <= 1'b0;
                    if (multi) begin
                        acc      <= '0;
                        x        <= a;
                        y        <= b;
                        is_mul_q <= (op == 4'hA);
`ifdef ALU_MULDIV_DIV_EN
                        is_rem_q <= (op == 4'hC);
                        dz_q     <= (op != 4'hA) && (b == '0);
`endif
                    end else begin
                        res_q <= alu_res;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (is_mul_q) begin
                        acc <= mul_sum;
                        x   <= x << 1;
                        y   <= y >> 1;
                        if (last) res_q <= mul_sum;
                    end
`ifdef ALU_MULDIV_DIV_EN
                    else begin
                        acc <= rem_nx;
                        x   <= quo_nx;
                        if (last) res_q <= is_rem_q ? rem_nx : quo_nx;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign out = res_q;
    assign dz  = dz_q;
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; legal range 4..32.
REQ-002 Port: clk  in  1  rising-edge clock, single clock domain.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  in  1  request present on op/a/b.
REQ-005 Port: in_ready  out  1  block can accept a request.
REQ-006 Port: op  in  4  operation select, encoding per REQ-012.
REQ-007 Port: a  in  WIDTH  first operand.
REQ-008 Port: b  in  WIDTH  second operand or shift amount.
REQ-009 Port: out_valid  out  1  result present on out/dz.
REQ-010 Port: out_ready  in  1  consumer takes result.
REQ-011 Port: out  out  WIDTH  result; dz  out  1  divide-by-zero flag.

Function
REQ-012 The op encoding SHALL be: 0 ADD a+b mod 2^W; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SHR logical; 6 SAR; 7 SHL; 8 LT signed (1/0); 9 LTU (1/0); A MUL, low W bits; B DIVU quotient; C REMU remainder; D-F pass a.
REQ-013 Shift ops SHALL use only b[clog2(WIDTH)-1:0] as the amount; upper b bits are ignored.
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-015 Accept = in_valid && in_ready; op/a/b SHALL be captured at accept and later input changes ignored.
REQ-016 Single-cycle ops (0-9, D-F) SHALL go IDLE->DONE; out_valid asserted the cycle after accept.
REQ-017 MUL SHALL be iterative shift-add, one bit per cycle: IDLE->BUSY for exactly WIDTH cycles ->DONE; out_valid WIDTH+1 cycles after accept.
REQ-018 DIVU/REMU SHALL be iterative restoring division, one bit per cycle, same timing as MUL.
REQ-019 When b==0, DIVU SHALL give all-ones, REMU SHALL give a, dz=1 with the result; otherwise dz=0.
REQ-020 In DONE, out_valid=1 and out/dz SHALL stay stable until out_ready=1; then DONE->IDLE next edge.
REQ-021 No accept in the same cycle as result hand-off; peak throughput one op per 2 cycles.
REQ-022 in_valid in BUSY/DONE SHALL be ignored with no state change.

Reset
REQ-023 rst_n low SHALL force IDLE immediately: out_valid=0, out=0, dz=0, in_ready=1, iteration counter=0.
REQ-024 Reset during BUSY or DONE SHALL abort the operation with no result ever presented.
REQ-025 After rst_n rises, the first accept SHALL be possible on the first clock edge.

Configuration
REQ-026 Macro ALU_MULDIV_DIV_EN defined: divider datapath present; ops B/C per REQ-018/019.
REQ-027 Macro ALU_MULDIV_DIV_EN undefined: no divider logic; ops B/C complete as single-cycle with out=0, dz=0. MUL unaffected.

Verification (WIDTH=16, DIV_EN defined unless noted)
REQ-028 ADD a=DEAD b=BEEF, out_ready=1 -> out=9D9C, dz=0, out_valid 1 cycle after accept; SUB a=2101 b=70FF -> B002; LT -> 0001; LTU -> 0001.
REQ-029 MUL a=00FE b=00CA -> out=C86C exactly 17 cycles after accept; in_ready=0 throughout BUSY.
REQ-030 DIVU a=DEAD b=0010 -> 0DEA; REMU -> 000D; DIVU a=1234 b=0000 -> FFFF dz=1; REMU -> 1234 dz=1.
REQ-031 SHR/SAR/SHL a=DEAD b=0014 (amount 4) -> 0DEA / FDEA / EAD0.
REQ-032 out_ready held 0 for 5 cycles in DONE with in_valid=1 and changing a/b -> out stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge.
REQ-033 rst_n low at cycle 5 of MUL -> out_valid=0, in_ready=1 while low, no result after release; rebuild without macro: DIVU a=DEAD b=0010 -> 0000 after 1 cycle.
